// File: rtl/am2910_seq.sv
// Am2910-style 12-bit microprogram sequencer: next-address select, R counter,
// 5-deep subroutine/loop stack, uPC incrementer, and active-low source enables.
module am2910_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  I,
    input  logic [11:0] D,
    input  logic        nCC,
    input  logic        nCCEN,
    input  logic        nRLD,
    input  logic        CI,
    input  logic        nOE,
    output logic [11:0] Y,
    output logic        nFULL,
    output logic        nPL,
    output logic        nMAP,
    output logic        nVECT
);

    typedef enum logic [3:0] {
        JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
        RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
    } op_e;

    localparam logic [2:0] DEPTH = 3'd5;

    logic [11:0] upc;
    logic [11:0] r;
    logic [2:0]  sp;
    logic [11:0] stack [0:4];

    op_e         op;
    logic        pass;
    logic        r_zero;
    logic [11:0] f;
    logic [11:0] y_int;
    logic        do_push;
    logic        do_pop;
    logic        do_clear;
    logic        r_load;
    logic        r_dec;

    assign op     = op_e'(I);
    assign pass   = nCCEN | ~nCC;
    assign r_zero = (r == 12'd0);
    // An empty stack presents zero as its top entry.
    assign f      = (sp == 3'd0) ? 12'd0 : stack[sp - 3'd1];

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        y_int    = upc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_clear = 1'b0;
        r_load   = 1'b0;
        r_dec    = 1'b0;
        case (op)
            JZ: begin
                y_int    = 12'd0;
                do_clear = 1'b1;
            end
            CJS: begin
                if (pass) begin
                    y_int   = D;
                    do_push = 1'b1;
                end
            end
            JMAP: y_int = D;
            CJP:  if (pass) y_int = D;
            PUSH: begin
                do_push = 1'b1;
                r_load  = pass;
            end
            JSRP: begin
                do_push = 1'b1;
                y_int   = pass ? D : r;
            end
            CJV:  if (pass) y_int = D;
            JRP:  y_int = pass ? D : r;
            RFCT: begin
                if (!r_zero) begin
                    y_int = f;
                    r_dec = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end
            RPCT: begin
                if (!r_zero) begin
                    y_int = D;
                    r_dec = 1'b1;
                end
            end
            CRTN: begin
                if (pass) begin
                    y_int  = f;
                    do_pop = 1'b1;
                end
            end
            CJPP: begin
                if (pass) begin
                    y_int  = D;
                    do_pop = 1'b1;
                end
            end
            LDCT: r_load = 1'b1;
            LOOP: begin
                if (pass) do_pop = 1'b1;
                else      y_int  = f;
            end
            CONT: y_int = upc;
            TWB: begin
                if (!r_zero && !pass) begin
                    y_int = f;
                    r_dec = 1'b1;
                end else begin
                    do_pop = 1'b1;
                    if (r_zero && !pass) y_int = D;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc <= 12'd0;
            r   <= 12'd0;
            sp  <= 3'd0;
            // NOTE: the stack array is reset too; a reset mid-subroutine must
            // leave no stale return addresses behind.
            for (int k = 0; k < 5; k++) stack[k] <= 12'd0;
        end else begin
            upc <= y_int + {11'd0, CI};

            if (!nRLD || r_load) r <= D;
            else if (r_dec)      r <= r - 12'd1;

            if (do_clear) begin
                sp <= 3'd0;
            end else if (do_push) begin
                // A full stack keeps its depth and overwrites the top entry.
                if (sp == DEPTH) begin
                    stack[4] <= upc;
                end else begin
                    stack[sp] <= upc;
                    sp        <= sp + 3'd1;
                end
            end else if (do_pop && sp != 3'd0) begin
                sp <= sp - 3'd1;
            end
        end
    end

    assign Y     = nOE ? 12'bz : y_int;
    assign nFULL = (sp != DEPTH);
    assign nMAP  = (I != 4'd2);
    assign nVECT = (I != 4'd6);
    assign nPL   = (I == 4'd2) || (I == 4'd6);

endmodule

// File: tb/tb_am2910_seq.sv
// Self-checking bench for am2910_seq: directed scenarios plus randomized
// instruction streams against a queue-based behavioural sequencer model.
module tb_am2910_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  i_in = 4'd14;
    logic [11:0] d_in = 12'd0;
    logic        ncc = 1'b1;
    logic        nccen = 1'b1;
    logic        nrld = 1'b1;
    logic        ci = 1'b0;
    logic        noe = 1'b0;
    wire  [11:0] y;
    wire         nfull, npl, nmap, nvect;

    int n_cmp = 0;
    int n_err = 0;

    am2910_seq dut (
        .clk   (clk),
        .reset (reset),
        .I     (i_in),
        .D     (d_in),
        .nCC   (ncc),
        .nCCEN (nccen),
        .nRLD  (nrld),
        .CI    (ci),
        .nOE   (noe),
        .Y     (y),
        .nFULL (nfull),
        .nPL   (npl),
        .nMAP  (nmap),
        .nVECT (nvect)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: program counter, loop counter, and a queue as the stack.
    logic [11:0] m_upc, m_r, m_y;
    logic [11:0] m_stk[$];
    logic [11:0] nx_r;
    bit          nx_push, nx_pop, nx_clear;

    task automatic model_reset();
        m_upc = 12'd0;
        m_r   = 12'd0;
        m_stk.delete();
    endtask

    task automatic model_eval();
        logic [11:0] top;
        bit ok, rz;
        top = (m_stk.size() == 0) ? 12'd0 : m_stk[m_stk.size() - 1];
        ok  = nccen || !ncc;
        rz  = (m_r == 0);
        nx_push = 0; nx_pop = 0; nx_clear = 0;
        nx_r = m_r;
        m_y  = m_upc;
        case (i_in)
            4'd0:  begin m_y = 0; nx_clear = 1; end
            4'd1:  if (ok) begin m_y = d_in; nx_push = 1; end
            4'd2:  m_y = d_in;
            4'd3:  if (ok) m_y = d_in;
            4'd4:  begin nx_push = 1; if (ok) nx_r = d_in; end
            4'd5:  begin nx_push = 1; m_y = ok ? d_in : m_r; end
            4'd6:  if (ok) m_y = d_in;
            4'd7:  m_y = ok ? d_in : m_r;
            4'd8:  if (!rz) begin m_y = top; nx_r = m_r - 1; end else nx_pop = 1;
            4'd9:  if (!rz) begin m_y = d_in; nx_r = m_r - 1; end
            4'd10: if (ok) begin m_y = top; nx_pop = 1; end
            4'd11: if (ok) begin m_y = d_in; nx_pop = 1; end
            4'd12: nx_r = d_in;
            4'd13: if (ok) nx_pop = 1; else m_y = top;
            4'd14: m_y = m_upc;
            default: begin
                if (!rz && !ok) begin m_y = top; nx_r = m_r - 1; end
                else begin nx_pop = 1; if (rz && !ok) m_y = d_in; end
            end
        endcase
        if (!nrld) nx_r = d_in;
    endtask

    task automatic model_commit();
        if (nx_clear) m_stk.delete();
        else if (nx_push) begin
            if (m_stk.size() < 5) m_stk.push_back(m_upc);
            else m_stk[4] = m_upc;
        end else if (nx_pop && m_stk.size() > 0) begin
            void'(m_stk.pop_back());
        end
        m_r   = nx_r;
        m_upc = (m_y + {11'd0, ci}) % 4096;
    endtask

    task automatic drive(input logic [3:0] i, input logic [11:0] d, input logic c,
                         input logic cen, input logic rld, input logic cin);
        @(negedge clk);
        i_in = i; d_in = d; ncc = c; nccen = cen; nrld = rld; ci = cin;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_commit();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            drive(4'd14, 12'hABC, 1'b1, 1'b1, 1'b1, 1'b1);
            n_cmp++; if (y !== 12'd0) begin n_err++; $display("FAIL reset_y: got %h expected 000", y); end
            n_cmp++; if (nfull !== 1'b1) begin n_err++; $display("FAIL reset_nfull: got %b expected 1", nfull); end
            n_cmp++; if ({npl, nmap, nvect} !== 3'b011) begin n_err++; $display("FAIL reset_flags: got %b expected 011", {npl, nmap, nvect}); end
            tick();
        end
    endtask

    task automatic test_count();
        logic [11:0] exp_y [4] = '{12'd0, 12'd1, 12'd2, 12'd3};
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
            n_cmp++; if (y !== exp_y[k]) begin n_err++; $display("FAIL count_y%0d: got %h expected %h", k, y, exp_y[k]); end
            n_cmp++; if (npl !== 1'b0 || nfull !== 1'b1) begin n_err++; $display("FAIL count_flags%0d: got npl=%b nfull=%b expected 0 1", k, npl, nfull); end
            tick();
        end
    endtask

    task automatic test_subroutine();
        drive(4'd3, 12'h00F, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'd1, 12'h200, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h200) begin n_err++; $display("FAIL cjs_y: got %h expected 200", y); end
        tick();
        drive(4'd10, 12'h777, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h010) begin n_err++; $display("FAIL crtn_y: got %h expected 010", y); end
        tick();
        drive(4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (y !== 12'h011) begin n_err++; $display("FAIL ret_upc: got %h expected 011", y); end
        tick();
        drive(4'd10, 12'h777, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h000) begin n_err++; $display("FAIL ret_empty: got %h expected 000", y); end
        tick();
    endtask

    task automatic test_loop();
        logic [11:0] exp_y [4] = '{12'h050, 12'h050, 12'h050, 12'h051};
        drive(4'd12, 12'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(4'd9, 12'h050, 1'b1, 1'b1, 1'b1, 1'b1);
            n_cmp++; if (y !== exp_y[k]) begin n_err++; $display("FAIL rpct_y%0d: got %h expected %h", k, y, exp_y[k]); end
            tick();
        end
    endtask

    task automatic test_stack_full();
        drive(4'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(4'd4, 12'h3FF, 1'b1, 1'b0, 1'b1, 1'b1);
            n_cmp++; if (nfull !== (k == 5 ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL push_nfull%0d: got %b expected %b", k, nfull, (k == 5 ? 1'b0 : 1'b1)); end
            tick();
        end
        drive(4'd10, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (nfull !== 1'b0) begin n_err++; $display("FAIL full_after6: got %b expected 0", nfull); end
        n_cmp++; if (y !== 12'h006) begin n_err++; $display("FAIL overwrite_top: got %h expected 006", y); end
        tick();
        drive(4'd10, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h004) begin n_err++; $display("FAIL pop_below: got %h expected 004", y); end
        tick();
        drive(4'd0, 12'h123, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h000) begin n_err++; $display("FAIL jz_y: got %h expected 000", y); end
        tick();
        drive(4'd10, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (nfull !== 1'b1 || y !== 12'h000) begin n_err++; $display("FAIL jz_clear: got nfull=%b y=%h expected 1 000", nfull, y); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(4'd1, 12'h300, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(4'd1, 12'h400, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (y !== 12'h000 || nfull !== 1'b1) begin n_err++; $display("FAIL async_reset: got y=%h nfull=%b expected 000 1", y, nfull); end
        tick();
        drive(4'd10, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h000) begin n_err++; $display("FAIL reset_stack: got %h expected 000", y); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_flags();
        for (int k = 0; k < 16; k++) begin
            logic [2:0] exp_f;
            exp_f = (k == 2) ? 3'b101 : (k == 6) ? 3'b110 : 3'b011;
            drive(k[3:0], 12'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            n_cmp++; if ({npl, nmap, nvect} !== exp_f) begin n_err++; $display("FAIL flags_i%0d: got %b expected %b", k, {npl, nmap, nvect}, exp_f); end
            tick();
        end
        drive(4'd3, 12'hFFE, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'hFFF) begin n_err++; $display("FAIL wrap_pre: got %h expected fff", y); end
        tick();
        drive(4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h000) begin n_err++; $display("FAIL wrap_post: got %h expected 000", y); end
        tick();
    endtask

    task automatic test_rld();
        drive(4'd12, 12'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(4'd8, 12'h123, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(4'd7, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (y !== 12'h123) begin n_err++; $display("FAIL rld_override: got %h expected 123", y); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            logic [11:0] d;
            logic [2:0]  exp_f;
            d = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 6)) : 12'($urandom);
            drive(4'($urandom), d, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0));
            exp_f = (i_in == 4'd2) ? 3'b101 : (i_in == 4'd6) ? 3'b110 : 3'b011;
            n_cmp++; if (y !== m_y) begin n_err++; $display("FAIL rand_y%0d i=%0d: got %h expected %h", k, i_in, y, m_y); end
            n_cmp++; if (nfull !== (m_stk.size() != 5)) begin n_err++; $display("FAIL rand_nfull%0d: got %b expected %b", k, nfull, (m_stk.size() != 5)); end
            n_cmp++; if ({npl, nmap, nvect} !== exp_f) begin n_err++; $display("FAIL rand_flags%0d: got %b expected %b", k, {npl, nmap, nvect}, exp_f); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_subroutine();
        test_loop();
        test_stack_full();
        test_async_reset();
        test_flags();
        test_rld();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
